my_div_param_seq: RTL and testbench

//  Parametrised sequential restoring divider: one quotient bit per clock, signed or unsigned per request.

---
 rtl/my_div_param_seq.sv | 128 ++++++++++++
 tb/tb_my_div_param_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/my_div_param_seq.sv
// Sequential restoring divider, one quotient bit per clock, signed or unsigned.
// Toggle handshake: a request is pending while run_in != run_out.
module my_div_param_seq #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   input  logic             run_in,
   output logic             run_out,
   output logic             busy,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   state_t             state_nx;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [2*WIDTH-1:0] bm;
   logic               qs;
   logic               rs;
   logic               dz;
   logic               ovf;

   logic             pend;
   logic             sgn;
   logic             dvd_neg;
   logic             dvs_neg;
   logic             dvs_zero;
   logic             is_ovf;
   logic             ge;
   logic             last;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   assign pend     = run_in != run_out;
   assign sgn      = is_signed & SIGNED_EN;
   assign dvd_neg  = sgn & dividend[WIDTH-1];
   assign dvs_neg  = sgn & divisor[WIDTH-1];
   assign dvd_mag  = dvd_neg ? -dividend : dividend;
   assign dvs_mag  = dvs_neg ? -divisor : divisor;
   assign dvs_zero = divisor == '0;
   assign is_ovf   = sgn & (dividend == MIN) & (divisor == '1);
   assign ge       = {{WIDTH{1'b0}}, rem} >= bm;
   assign last     = count == CW'(WIDTH-1);
   assign busy     = state != IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (pend) state_nx = dvs_zero ? FIX : CALC;
         CALC: begin
            if (!pend)     state_nx = IDLE;
            else if (last) state_nx = FIX;
         end
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Divide by zero preloads quo/rem so FIX emits all-ones and the raw dividend.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         bm       <= '0;
         qs       <= 1'b0;
         rs       <= 1'b0;
         dz       <= 1'b0;
         ovf      <= 1'b0;
         q        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
         overflow <= 1'b0;
         run_out  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pend) begin
                  count <= '0;
                  quo   <= dvs_zero ? '1 : '0;
                  rem   <= dvs_zero ? dividend : dvd_mag;
                  bm    <= {{WIDTH{1'b0}}, dvs_mag} << (WIDTH-1);
                  qs    <= ~dvs_zero & (dvd_neg ^ dvs_neg);
                  rs    <= ~dvs_zero & dvd_neg;
                  dz    <= dvs_zero;
                  ovf   <= is_ovf;
               end
            end
            CALC: begin
               if (pend) begin
                  if (ge) rem <= rem - bm[WIDTH-1:0];
                  quo   <= {quo[WIDTH-2:0], ge};
                  bm    <= bm >> 1;
                  count <= count + 1'b1;
               end
            end
            FIX: begin
               q        <= qs ? -quo : quo;
               r        <= rs ? -rem : rem;
               div_zero <= dz;
               overflow <= ovf;
               run_out  <= ~run_out;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_my_div_param_seq.sv
// Bench for my_div_param_seq: 32-bit signed/unsigned-only builds and an 8-bit build.
module tb_my_div_param_seq;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
      logic [7:0]  lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        is_signed;
   logic        run_in;

   logic        ro_a, busy_a, dz_a, ov_a;
   logic [31:0] q_a, r_a;
   logic        ro_b, busy_b, dz_b, ov_b;
   logic [31:0] q_b, r_b;

   logic [7:0]  dvd8, dvs8, q8, r8;
   logic        sg8, ri8, ro8, busy8, dz8, ov8;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t sb8[$];
   exp_t last_a;
   exp_t last_b;

   always #5 clk = ~clk;

   my_div_param_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u_a (
      .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
      .is_signed(is_signed), .run_in(run_in), .run_out(ro_a),
      .busy(busy_a), .q(q_a), .r(r_a), .div_zero(dz_a), .overflow(ov_a));

   my_div_param_seq #(.WIDTH(32), .SIGNED_EN(1'b0)) u_b (
      .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
      .is_signed(is_signed), .run_in(run_in), .run_out(ro_b),
      .busy(busy_b), .q(q_b), .r(r_b), .div_zero(dz_b), .overflow(ov_b));

   my_div_param_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_8 (
      .clk(clk), .rst(rst), .dividend(dvd8), .divisor(dvs8),
      .is_signed(sg8), .run_in(ri8), .run_out(ro8),
      .busy(busy8), .q(q8), .r(r8), .div_zero(dz8), .overflow(ov8));

   function automatic exp_t model(int w, logic [31:0] n, logic [31:0] d,
                                  logic s, bit se);
      exp_t   e;
      longint mask;
      longint sn;
      longint sd;
      longint qq;
      longint rr;
      bit     sg;
      mask = (longint'(1) << w) - 1;
      sg   = s && se;
      e.lat = (d == 0) ? 8'd2 : 8'(w + 2);
      if (d == 0) begin
         e.q  = 32'(mask);
         e.r  = n;
         e.dz = 1'b1;
         e.ov = 1'b0;
         return e;
      end
      sn = longint'(n);
      sd = longint'(d);
      if (sg && n[w-1]) sn = sn - (longint'(1) << w);
      if (sg && d[w-1]) sd = sd - (longint'(1) << w);
      qq = sn / sd;
      rr = sn % sd;
      e.q  = 32'(qq & mask);
      e.r  = 32'(rr & mask);
      e.dz = 1'b0;
      e.ov = sg && (n == 32'(longint'(1) << (w-1))) && (d == 32'(mask));
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0 ] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run32(input logic [31:0] n, input logic [31:0] d,
                        input logic s);
      int k;
      int bz;
      sb_a.push_back(model(32, n, d, s, 1'b1));
      sb_b.push_back(model(32, n, d, s, 1'b0));
      dividend  = n;
      divisor   = d;
      is_signed = s;
      run_in    = ~run_in;
      k  = 0;
      bz = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) begin
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = ~s;
         end
         if (busy_a) bz++;
      end while (ro_a != run_in && k < 100);
      last_a = sb_a.pop_front();
      last_b = sb_b.pop_front();
      chk("q_a", q_a, last_a.q);
      chk("r_a", r_a, last_a.r);
      chk("dz_a", 32'(dz_a), 32'(last_a.dz));
      chk("ov_a", 32'(ov_a), 32'(last_a.ov));
      chk("lat_a", 32'(k), 32'(last_a.lat));
      chk("busy_a", 32'(bz), 32'(last_a.lat) - 1);
      chk("q_b", q_b, last_b.q);
      chk("r_b", r_b, last_b.r);
      chk("dz_b", 32'(dz_b), 32'(last_b.dz));
      chk("ov_b", 32'(ov_b), 32'(last_b.ov));
      chk("ro_b", 32'(ro_b), 32'(run_in));
   endtask

   task automatic run8(input logic [7:0] n, input logic [7:0] d,
                       input logic s);
      int   k;
      exp_t e;
      sb8.push_back(model(8, 32'(n), 32'(d), s, 1'b1));
      dvd8 = n;
      dvs8 = d;
      sg8  = s;
      ri8  = ~ri8;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) begin
            dvd8 = 8'($urandom);
            dvs8 = 8'($urandom);
            sg8  = ~s;
         end
      end while (ro8 != ri8 && k < 40);
      e = sb8.pop_front();
      chk("q8", 32'(q8), e.q);
      chk("r8", 32'(r8), e.r);
      chk("dz8", 32'(dz8), 32'(e.dz));
      chk("ov8", 32'(ov8), 32'(e.ov));
      chk("lat8", 32'(k), 32'(e.lat));
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_q_a"}, q_a, 32'd0);
      chk({tag, "_r_a"}, r_a, 32'd0);
      chk({tag, "_ro_a"}, 32'(ro_a), 32'd0);
      chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
      chk({tag, "_flags_a"}, 32'({dz_a, ov_a}), 32'd0);
      chk({tag, "_q_b"}, q_b, 32'd0);
      chk({tag, "_ro8"}, 32'(ro8), 32'd0);
      chk({tag, "_q8"}, 32'(q8), 32'd0);
   endtask

   initial begin
      logic ro_hold;
      rst       = 1'b1;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      run_in    = 1'b0;
      dvd8      = '0;
      dvs8      = '0;
      sg8       = 1'b0;
      ri8       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      run32(32'd100, 32'd7, 1'b0);
      run32(32'hFFFFFFF9, 32'd2, 1'b1);
      run32(32'hFFFFFFF9, 32'd2, 1'b0);
      run32(32'd5, 32'd0, 1'b1);
      run32(32'd9, 32'd3, 1'b1);
      run32(32'h80000000, 32'hFFFFFFFF, 1'b1);
      run32(32'h80000000, 32'hFFFFFFFF, 1'b0);
      run32(-32'sd100, 32'd7, 1'b1);
      run32(32'd100, -32'sd7, 1'b1);
      run32(-32'sd100, -32'sd7, 1'b1);
      run32(32'hFFFFFFFF, 32'd0, 1'b0);
      run32(32'd3, 32'd10, 1'b1);
      run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run32(32'h80000000, 32'd1, 1'b1);
      for (int i = 0; i < 8; i++)
         run32($urandom, 32'($urandom_range(1, 100000)), 1'($urandom));

      // Abort: requester toggles back during CALC
      ro_hold   = run_in;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      is_signed = 1'b0;
      run_in    = ~run_in;
      repeat (10) @(posedge clk);
      #1;
      run_in = ~run_in;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(busy_a), 32'd0);
      chk("abort_ro", 32'(ro_a), 32'(ro_hold));
      chk("abort_q", q_a, last_a.q);
      chk("abort_r", r_a, last_a.r);
      repeat (40) @(posedge clk);
      #1;
      chk("abort_ro_late", 32'(ro_a), 32'(ro_hold));
      chk("abort_q_late", q_a, last_a.q);
      run32(32'd1000, 32'd3, 1'b0);

      // Asynchronous reset in the middle of an operation
      dividend = 32'd50;
      divisor  = 32'd5;
      run_in   = ~run_in;
      repeat (5) @(posedge clk);
      #1;
      rst    = 1'b1;
      run_in = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run32(32'd9, 32'd3, 1'b1);

      run8(8'h80, 8'hFF, 1'b1);
      run8(8'h80, 8'hFF, 1'b0);
      run8(8'h7F, 8'h00, 1'b1);
      run8(8'h00, 8'h00, 1'b0);
      run8(8'hFF, 8'h01, 1'b1);
      run8(8'h81, 8'h7F, 1'b1);
      run8(8'h01, 8'h80, 1'b1);
      run8(8'h80, 8'h80, 1'b1);
      for (int i = 0; i < 400; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
